// File: rtl/decode_issue_scoreboard.sv
// ============================================================================
// Module      : decode_issue_scoreboard
// Description : Decode-stage register-dependency scoreboard and issue control.
//               Optional writeback bypass: SCOREBOARD_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CW           = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic        dec_wr_rd,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic        wb_wren,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic [31:0] pending_mask,
    output logic [3:0]  inflight,
    output logic [15:0] stall_cycles
);

    localparam logic [CW-1:0] c_cnt_max      = {CW{1'b1}};
    localparam logic [3:0]    c_max_inflight = 4'(MAX_INFLIGHT);

    logic [CW-1:0] r_cnt      [32];
    logic [CW-1:0] w_cnt_nxt  [32];
    logic [31:0]   r_pending_mask;
    logic [3:0]    r_inflight;
    logic [3:0]    w_inflight_nxt;
    logic [15:0]   r_stall_cycles;

    logic w_wb_wr;
    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_rs1_byp;
    logic w_rs2_byp;
    logic w_hazard;
    logic w_full;
    logic w_fire;

    assign w_wb_wr    = wb_valid & wb_wren & (wb_rd != 5'd0);
    assign w_rs1_busy = dec_use_rs1 & (dec_rs1 != 5'd0) & (r_cnt[dec_rs1] != '0);
    assign w_rs2_busy = dec_use_rs2 & (dec_rs2 != 5'd0) & (r_cnt[dec_rs2] != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last outstanding writer retiring now is visible through the
    // falling-edge register-file write, so it no longer blocks the read.
    assign w_rs1_byp = w_wb_wr & (wb_rd == dec_rs1) & (r_cnt[dec_rs1] == CW'(1));
    assign w_rs2_byp = w_wb_wr & (wb_rd == dec_rs2) & (r_cnt[dec_rs2] == CW'(1));
`else
    assign w_rs1_byp = 1'b0;
    assign w_rs2_byp = 1'b0;
`endif

    assign w_hazard    = (w_rs1_busy & ~w_rs1_byp) | (w_rs2_busy & ~w_rs2_byp);
    assign w_full      = (r_inflight == c_max_inflight) & ~wb_valid;
    assign issue_ready = ~w_hazard & ~w_full & ~flush;
    assign w_fire      = dec_valid & issue_ready;

    assign w_cnt_nxt[0] = '0;

    for (genvar n = 1; n < 32; n++) begin : g_cnt
        logic w_inc;
        logic w_dec;

        assign w_inc = w_fire & dec_wr_rd & (dec_rd == 5'(n));
        assign w_dec = w_wb_wr & (wb_rd == 5'(n));

        // A simultaneous increment and decrement nets to no change.
        assign w_cnt_nxt[n] = flush                                      ? '0 :
                              (w_inc & ~w_dec & (r_cnt[n] != c_cnt_max)) ? r_cnt[n] + CW'(1) :
                              (w_dec & ~w_inc & (r_cnt[n] != '0))        ? r_cnt[n] - CW'(1) :
                                                                           r_cnt[n];
    end

    assign w_inflight_nxt = flush                                            ? 4'd0 :
                            (w_fire & ~wb_valid & (r_inflight != 4'hF))      ? r_inflight + 4'd1 :
                            (wb_valid & ~w_fire & (r_inflight != 4'd0))      ? r_inflight - 4'd1 :
                                                                               r_inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
            r_pending_mask <= '0;
            r_inflight     <= '0;
            r_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i]          <= w_cnt_nxt[i];
                r_pending_mask[i] <= (w_cnt_nxt[i] != '0);
            end
            r_inflight <= w_inflight_nxt;
            if (dec_valid && !issue_ready && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign pending_mask = r_pending_mask;
    assign inflight     = r_inflight;
    assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue_scoreboard.sv
// ============================================================================
// Module      : tb_decode_issue_scoreboard
// Description : Table-driven self-checking bench for decode_issue_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_issue_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic        w;
        logic        wbv;
        logic        wbw;
        logic [4:0]  wbrd;
        logic        fl;
        logic        rdy;
        logic [31:0] mask;
        logic [3:0]  inf;
        logic [15:0] stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        dec_wr_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic        wb_wren;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] pending_mask;
    logic [3:0]  inflight;
    logic [15:0] stall_cycles;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    decode_issue_scoreboard #(.MAX_INFLIGHT(4), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .dec_use_rs1  (dec_use_rs1),
        .dec_use_rs2  (dec_use_rs2),
        .dec_wr_rd    (dec_wr_rd),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_wren      (wb_wren),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .pending_mask (pending_mask),
        .inflight     (inflight),
        .stall_cycles (stall_cycles)
    );

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u1, input logic u2, input logic w,
                                input logic wbv, input logic wbw, input logic [4:0] wbrd,
                                input logic fl, input logic rdy, input logic [31:0] mask,
                                input logic [3:0] inf, input logic [15:0] stall);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2; r.w = w;
        r.wbv = wbv; r.wbw = wbw; r.wbrd = wbrd; r.fl = fl;
        r.rdy = rdy; r.mask = mask; r.inf = inf; r.stall = stall;
        return r;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        dec_valid   = t.v;
        dec_rs1     = t.rs1;
        dec_rs2     = t.rs2;
        dec_rd      = t.rd;
        dec_use_rs1 = t.u1;
        dec_use_rs2 = t.u2;
        dec_wr_rd   = t.w;
        wb_valid    = t.wbv;
        wb_wren     = t.wbw;
        wb_rd       = t.wbrd;
        flush       = t.fl;
    endtask

    initial begin
        logic [15:0] s;
        s = c_byp ? 16'd2 : 16'd3;

        // back-to-back RAW on x5
        vecs.push_back(mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1,      32'h20, 1, 0));
        vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,      32'h20, 1, 1));
        vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,      32'h20, 1, 2));
        vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 1, 1, 5, 0, c_byp,  32'h0,  c_byp ? 4'd1 : 4'd0, s));
        vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1,      32'h0,  c_byp ? 4'd2 : 4'd1, s));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,      32'h0,  0, s));
        // x0 never tracked
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1,      32'h0,  1, s));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1,      32'h0,  2, s));
        // window full
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1,      32'h2,  3, s));
        vecs.push_back(mk(1, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 1,      32'h6,  4, s));
        vecs.push_back(mk(1, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0,      32'h6,  4, s + 16'd1));
        vecs.push_back(mk(1, 0, 0, 6, 0, 0, 1, 1, 1, 1, 0, 1,      32'h44, 4, s + 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,      32'h0,  0, s + 16'd1));
        // duplicate rd
        vecs.push_back(mk(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1,      32'h80, 1, s + 16'd1));
        vecs.push_back(mk(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1,      32'h80, 2, s + 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 1,      32'h80, 1, s + 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 1,      32'h0,  0, s + 16'd1));
        // flush then stale wb
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1,      32'h8,  1, s + 16'd1));
        vecs.push_back(mk(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 1,      32'h18, 2, s + 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 0,      32'h0,  0, s + 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 1,      32'h0,  0, s + 16'd1));
        vecs.push_back(mk(1, 3, 4, 9, 1, 1, 1, 0, 0, 0, 0, 1,      32'h200, 1, s + 16'd1));
        // rs2-only hazard, then same regs with use bits clear
        vecs.push_back(mk(1, 0, 9, 0, 1, 1, 0, 0, 0, 0, 0, 0,      32'h200, 1, s + 16'd2));
        vecs.push_back(mk(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1,      32'h200, 2, s + 16'd2));

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("reset_ready", -1, 32'(issue_ready), 32'd1);
        check("reset_mask",  -1, pending_mask, 32'h0);
        check("reset_inflight", -1, 32'(inflight), 32'd0);
        check("reset_stall", -1, 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check("issue_ready", i, 32'(issue_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check("pending_mask", i, pending_mask, vecs[i].mask);
            check("inflight", i, 32'(inflight), 32'(vecs[i].inf));
            check("stall_cycles", i, 32'(stall_cycles), 32'(vecs[i].stall));
        end

        // async reset while stalled on x9
        @(negedge clk);
        drive(mk(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("stall_ready", 100, 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1;
        check("stall_count", 100, 32'(stall_cycles), 32'(s + 16'd3));
        #2;
        rst = 1'b1;
        #1;
        check("async_mask", 101, pending_mask, 32'h0);
        check("async_inflight", 101, 32'(inflight), 32'd0);
        check("async_stall", 101, 32'(stall_cycles), 32'd0);
        check("async_ready", 101, 32'(issue_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_inflight", 102, 32'(inflight), 32'd1);
        check("post_reset_stall", 102, 32'(stall_cycles), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
